// File: rtl/rle_word_packer.sv
// rle_word_packer: packs 1-4 valid bytes per input word into dense 32-bit
// little-endian words; a flush zero-pads and emits any partial word.
module rle_word_packer (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  disabledGroups,
    input  logic [31:0] dataIn,
    input  logic        validIn,
    input  logic        flush,
    output logic [31:0] dataOut,
    output logic        validOut,
    output logic        flushDone,
    output logic        busy,
    output logic        overflow
);

    typedef enum logic {
        IDLE,
        FLUSH_PEND
    } state_t;

    state_t      state, state_nxt;
    logic [23:0] residue, residue_nxt;
    logic [1:0]  fill, fill_nxt;
    logic [3:0]  mask_reg, mask_nxt;
    logic [31:0] dout_nxt;
    logic        valid_nxt, done_nxt, busy_nxt, ovf_nxt;

    logic [2:0]  n_bytes;
    logic [31:0] din_masked;
    logic [55:0] comb;
    logic [2:0]  total;
    logic        accept;
    logic        full;
    logic [1:0]  fill_acc;
    logic [23:0] res_acc;

    // Bytes per input word: one per enabled channel group.
    always_comb begin
        n_bytes = 3'd4 - ({2'b00, mask_reg[0]} + {2'b00, mask_reg[1]}
                        + {2'b00, mask_reg[2]} + {2'b00, mask_reg[3]});
    end

    // Keep only the valid low bytes of the input word.
    always_comb begin
        case (n_bytes)
            3'd1:    din_masked = {24'b0, dataIn[7:0]};
            3'd2:    din_masked = {16'b0, dataIn[15:0]};
            3'd3:    din_masked = {8'b0, dataIn[23:0]};
            3'd4:    din_masked = dataIn;
            default: din_masked = '0;
        endcase
    end

    // Accept path: append new bytes above the pending residue.
    always_comb begin
        accept   = (state == IDLE) && validIn && (n_bytes != 3'd0);
        comb     = ({24'b0, din_masked} << {fill, 3'b000}) | {32'b0, residue};
        total    = {1'b0, fill} + n_bytes;
        full     = 1'b0;
        fill_acc = fill;
        res_acc  = residue;
        if (accept) begin
            if (total[2]) begin
                full     = 1'b1;
                res_acc  = comb[55:32];
                fill_acc = total[1:0];
            end else begin
                res_acc  = comb[23:0];
                fill_acc = total[1:0];
            end
        end
    end

    // Next-state and registered-output values.
    always_comb begin
        state_nxt   = state;
        residue_nxt = residue;
        fill_nxt    = fill;
        mask_nxt    = mask_reg;
        dout_nxt    = dataOut;
        valid_nxt   = 1'b0;
        done_nxt    = 1'b0;
        ovf_nxt     = overflow;

        if (state == FLUSH_PEND) begin
            dout_nxt    = {8'b0, residue};
            valid_nxt   = 1'b1;
            done_nxt    = 1'b1;
            fill_nxt    = 2'd0;
            residue_nxt = '0;
            state_nxt   = IDLE;
            if (validIn) ovf_nxt = 1'b1;
        end else begin
            residue_nxt = res_acc;
            fill_nxt    = fill_acc;
            if (full) begin
                dout_nxt  = comb[31:0];
                valid_nxt = 1'b1;
            end
            // Mask changes only take effect once the packer is empty.
            if ((fill == 2'd0) && !validIn) mask_nxt = disabledGroups;
            if (flush) begin
                // A full word and leftover bytes cannot share one write slot,
                // so the padded remainder is deferred by one cycle.
                if (full && (fill_acc != 2'd0)) begin
                    state_nxt = FLUSH_PEND;
                end else begin
                    if (!full && (fill_acc != 2'd0)) begin
                        dout_nxt  = {8'b0, res_acc};
                        valid_nxt = 1'b1;
                    end
                    done_nxt    = 1'b1;
                    fill_nxt    = 2'd0;
                    residue_nxt = '0;
                end
            end
        end
        busy_nxt = (state_nxt == FLUSH_PEND);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            residue   <= '0;
            fill      <= 2'd0;
            mask_reg  <= '0;
            dataOut   <= '0;
            validOut  <= 1'b0;
            flushDone <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nxt;
            residue   <= residue_nxt;
            fill      <= fill_nxt;
            mask_reg  <= mask_nxt;
            dataOut   <= dout_nxt;
            validOut  <= valid_nxt;
            flushDone <= done_nxt;
            busy      <= busy_nxt;
            overflow  <= ovf_nxt;
        end
    end

endmodule
